lfsr_gen: RTL
=============

# lfsr_gen

Parametrised Galois LFSR pseudo-random source with a valid/ready output stream, runtime seed load, and period-wrap detection. It generalises the fixed 32-bit and 10-bit data/address LFSRs to any width, tap polynomial and number of shifts per advance. It feeds AXI traffic and test-pattern generators as a single stream source. One instance is used per data or address channel.

## Interface
- WIDTH, 32: state/output width, 2..64.
- TAPS, 32'h0040_0007: Galois feedback mask.
  - Bit i set means state bit i is XORed with the feedback bit.
  - Bit 0 must be 1.
  - Default is x^32+x^22+x^2+x^1+1.
- SEED, all ones: reset/fallback state. Must be nonzero.
- STEPS, 1: LFSR shifts per accepted word, 1..WIDTH.
- CNT_W, 16: width of the accepted-word counter.

Ports (name, direction, width, meaning):
- clk, in, 1: clock. All logic is on the rising edge.
- rstn, in, 1: synchronous active-low reset.
- seed_load, in, 1: load seed_in into the state this cycle.
- seed_in, in, WIDTH: runtime seed.
- out_valid, out, 1: out_data holds a valid word.
- out_ready, in, 1: consumer accepts out_data.
- out_data, out, WIDTH: current LFSR state, registered.
- wrap, out, 1: one-cycle pulse when the sequence returns to its start state.
- word_cnt, out, CNT_W: number of accepted words since the last reset or seed load. Wraps modulo 2^CNT_W.

## Operation
- Single-step function adv1(s):
  - {s[WIDTH-2:0],1'b0} XOR (s[WIDTH-1] ? TAPS[WIDTH-1:0] : 0).
- adv(s) is adv1 applied STEPS times, all within one cycle (combinational unroll).
- Internal registers:
  - state: drives out_data.
  - start: the last loaded start state.
  - valid flag.
  - word counter.
- Effective seed:
  - seed_in when it is nonzero.
  - SEED when seed_in == 0, so the all-zero lock-up state can never be loaded.
- Transfer: out_valid && out_ready on a rising edge.
- Per-cycle priority, highest first:
  1. rstn == 0:
     - state <= SEED, start <= SEED.
     - out_valid <= 0, word_cnt <= 0, wrap <= 0.
  2. seed_load == 1:
     - state <= effective seed, start <= effective seed.
     - out_valid <= 0, word_cnt <= 0, wrap <= 0.
     - Any transfer in the same cycle is dropped: not counted, state not advanced.
  3. !out_valid:
     - out_valid <= 1. State is unchanged.
  4. Transfer:
     - state <= adv(state).
     - word_cnt <= word_cnt + 1, wrapping at 2^CNT_W.
     - wrap <= (adv(state) == start).
  5. Otherwise: hold everything, wrap <= 0.
- out_data and out_valid are stable while out_valid && !out_ready (AXI-stream rule).
- out_valid never drops except on reset or seed_load.
- wrap is 0 in every cycle without a transfer.
- With a primitive TAPS and STEPS coprime to 2^WIDTH-1, wrap first asserts on accepted word number 2^WIDTH-1.
- word_cnt overflow does not affect wrap.

## Timing
- Reset values:
  - out_valid = 0, out_data = SEED, wrap = 0, word_cnt = 0.
- First valid word:
  - out_valid = 1 in the second cycle after the first rising edge with rstn high.
  - That is one bubble cycle after reset release.
- Seed load:
  - out_data = effective seed on the edge where seed_load is sampled.
  - out_valid = 0 in that cycle, then 1 one cycle later.
- Throughput: one word per cycle while out_ready is held high.
- Latency, transfer to next word: out_data updates on the same edge that samples the transfer.
- wrap and word_cnt update on that same edge. wrap is registered and aligned with the new out_data.
- Reset mid-stream has priority over seed_load and any transfer. There is no partial advance.
- out_ready is ignored while out_valid = 0. Asserting it early has no effect.

## Test plan
- Default params, reset, out_ready = 1:
  - out_valid rises after 1 bubble cycle.
  - Words are 32'hFFFFFFFF, then 32'hFFBFFFF9.
  - word_cnt = 1 after the first transfer.
- WIDTH=10, TAPS=10'h009, SEED=10'h3FF, out_ready = 1:
  - Words are 10'h3FF, 10'h3F7, 10'h3E7.
  - wrap pulses exactly once, on accepted word 1023, when out_data returns to 10'h3FF.
  - No repeat of any value before that point.
- Same params with STEPS=2:
  - Words are 10'h3FF, 10'h3E7.
  - wrap on accepted word 1023, since 2 is coprime to 1023.
- Backpressure: toggle out_ready 1,0,0,1 pseudo-randomly:
  - out_data holds while stalled.
  - No word is skipped or duplicated versus the reference model.
  - word_cnt equals the number of handshakes.
- seed_load with seed_in = 10'h155 in the same cycle as a transfer:
  - That transfer is dropped.
  - out_data = 10'h155, out_valid = 0 for 1 cycle, word_cnt = 0.
  - wrap occurs 1023 words later, at 10'h155.
- seed_load with seed_in = 0:
  - out_data = SEED.
  - Reset asserted mid-stream with out_ready high gives out_data = SEED, out_valid = 0, word_cnt = 0 on the next edge.

Source files
------------

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Galois LFSR word source with a valid/ready output
// stream, runtime seed load and period-wrap detection. out_data is the
// registered LFSR state, and it advances by STEPS shifts on each accepted word.
module lfsr_gen #(
    parameter int              WIDTH = 32,
    parameter logic [63:0]     TAPS  = 64'h0000_0000_0040_0007,
    parameter logic [WIDTH-1:0] SEED = {WIDTH{1'b1}},
    parameter int              STEPS = 1,
    parameter int              CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             wrap,
    output logic [CNT_W-1:0] word_cnt
);

    // Feedback mask trimmed to the state width. Bit 0 must be set so the
    // feedback bit always re-enters at the bottom of the register.
    localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH-1:0];

    // Stream handshake: a word transfers on a rising edge where
    // out_valid && out_ready. While out_valid is high and the word is not
    // taken, out_data and out_valid stay put. out_valid only falls on reset or
    // seed load. out_ready is ignored while out_valid is low.

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] start_q;
    logic             valid_q;
    logic             wrap_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] next_state;
    logic [WIDTH-1:0] eff_seed;
    logic             xfer;

    // One Galois shift: shift left, and fold the bit that fell out of the
    // top back in through the tap mask.
    function automatic logic [WIDTH-1:0] adv1(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? TAP_MASK : '0);
    endfunction

    // STEPS shifts in one cycle. The loop unrolls into a chain of XORs.
    function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] r;
        r = s;
        for (int i = 0; i < STEPS; i++) begin
            r = adv1(r);
        end
        return r;
    endfunction

    // Next LFSR word, the seed actually loaded, and the handshake decode.
    // A zero seed falls back to SEED, so the all-zero lock-up state can
    // never be loaded.
    always_comb begin
        next_state = adv(state_q);
        eff_seed   = (seed_in != '0) ? seed_in : SEED;
        xfer       = valid_q && out_ready;
    end

    // Priority: reset, then seed load (drops a coincident transfer), then
    // refilling out_valid, then advancing on a transfer, else hold.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= SEED;
            start_q <= SEED;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else if (seed_load) begin
            state_q <= eff_seed;
            start_q <= eff_seed;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else if (!valid_q) begin
            valid_q <= 1'b1;
            wrap_q  <= 1'b0;
        end else if (xfer) begin
            state_q <= next_state;
            cnt_q   <= cnt_q + 1'b1;
            wrap_q  <= (next_state == start_q);
        end else begin
            wrap_q  <= 1'b0;
        end
    end

    assign out_data  = state_q;
    assign out_valid = valid_q;
    assign wrap      = wrap_q;
    assign word_cnt  = cnt_q;

    // A stalled word must stay on the bus, unchanged, until it is taken.
    a_hold_stable: assert property (@(posedge clk) disable iff (!rstn)
        (out_valid && !out_ready && !seed_load) |=> (out_valid && $stable(out_data)));

endmodule
